// File: rtl/ahb_out_stage_rr_if.sv
// ahb_out_stage_rr_if: per-port input-stage fields and the shared slave-port signals of one output stage
interface ahb_out_stage_rr_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 32
);
  logic [NUM_PORTS-1:0]        sel_op, held_tran_op, write_op, mastlock_op;
  logic [2*NUM_PORTS-1:0]      trans_op;
  logic [3*NUM_PORTS-1:0]      size_op, burst_op;
  logic [4*NUM_PORTS-1:0]      prot_op, master_op;
  logic [ADDR_W*NUM_PORTS-1:0] addr_op;
  logic [USER_W*NUM_PORTS-1:0] auser_op, wuser_op;
  logic [DATA_W*NUM_PORTS-1:0] wdata_op;
  logic                        HREADYOUTM;
  logic [NUM_PORTS-1:0]        active_op;
  logic                        HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
  logic [1:0]                  HTRANSM;
  logic [2:0]                  HSIZEM, HBURSTM;
  logic [3:0]                  HPROTM, HMASTERM;
  logic [ADDR_W-1:0]           HADDRM;
  logic [USER_W-1:0]           HAUSERM, HWUSERM;
  logic [DATA_W-1:0]           HWDATAM;
  modport slave (
    input  sel_op, held_tran_op, write_op, mastlock_op, trans_op, size_op, burst_op, prot_op,
           master_op, addr_op, auser_op, wuser_op, wdata_op, HREADYOUTM,
    output active_op, HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM, HTRANSM, HSIZEM, HBURSTM,
           HPROTM, HMASTERM, HADDRM, HAUSERM, HWUSERM, HWDATAM
  );
  modport master (
    output sel_op, held_tran_op, write_op, mastlock_op, trans_op, size_op, burst_op, prot_op,
           master_op, addr_op, auser_op, wuser_op, wdata_op, HREADYOUTM,
    input  active_op, HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM, HTRANSM, HSIZEM, HBURSTM,
           HPROTM, HMASTERM, HADDRM, HAUSERM, HWUSERM, HWDATAM
  );
endinterface

// File: rtl/ahb_out_stage_rr.sv
// ahb_out_stage_rr: N-port AHB output stage with registered round-robin arbitration, lock and burst hold
// Define AHB_OSTG_FIXED_PRIO_EN to make the lowest-index requesting port win instead of rotating.
module ahb_out_stage_rr #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int USER_W    = 32
) (
  input logic               HCLK,
  input logic               HRESET,
  ahb_out_stage_rr_if.slave bus
);
  localparam int PIDX_W = $clog2(NUM_PORTS);
  logic [PIDX_W-1:0]    grant_q, rr_ptr_q, data_port_q, win;
  logic                 no_port_q, data_vld_q, slave_sel_q, hsel_lock_q, hsel_lock_d, hlock_arb, hold, any_req;
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic [NUM_PORTS-1:0] req;
  logic [1:0]           trans_a [NUM_PORTS];
  logic [2:0]           size_a [NUM_PORTS], burst_a [NUM_PORTS];
  logic [3:0]           prot_a [NUM_PORTS], master_a [NUM_PORTS];
  logic [ADDR_W-1:0]    addr_a [NUM_PORTS];
  logic [USER_W-1:0]    auser_a [NUM_PORTS], wuser_a [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_a [NUM_PORTS];
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign trans_a[p]  = bus.trans_op[2*p +: 2];
    assign size_a[p]   = bus.size_op[3*p +: 3];
    assign burst_a[p]  = bus.burst_op[3*p +: 3];
    assign prot_a[p]   = bus.prot_op[4*p +: 4];
    assign master_a[p] = bus.master_op[4*p +: 4];
    assign addr_a[p]   = bus.addr_op[ADDR_W*p +: ADDR_W];
    assign auser_a[p]  = bus.auser_op[USER_W*p +: USER_W];
    assign wuser_a[p]  = bus.wuser_op[USER_W*p +: USER_W];
    assign wdata_a[p]  = bus.wdata_op[DATA_W*p +: DATA_W];
  end
  assign req            = bus.sel_op & bus.held_tran_op;
  assign any_req        = |req;
  assign bus.active_op  = no_port_q ? '0 : NUM_PORTS'(1) << grant_q;
  assign bus.HSELM      = !no_port_q & bus.sel_op[grant_q];
  assign bus.HWRITEM    = !no_port_q & bus.write_op[grant_q];
  assign bus.HMASTLOCKM = !no_port_q & bus.mastlock_op[grant_q];
  assign bus.HTRANSM    = no_port_q ? 2'b00 : trans_a[grant_q];
  assign bus.HSIZEM     = no_port_q ? 3'b000 : size_a[grant_q];
  assign bus.HBURSTM    = no_port_q ? 3'b000 : burst_a[grant_q];
  assign bus.HPROTM     = no_port_q ? 4'h0 : prot_a[grant_q];
  assign bus.HMASTERM   = no_port_q ? 4'h0 : master_a[grant_q];
  assign bus.HADDRM     = no_port_q ? '0 : addr_a[grant_q];
  assign bus.HAUSERM    = no_port_q ? '0 : auser_a[grant_q];
  assign bus.HWDATAM    = data_vld_q ? wdata_a[data_port_q] : '0;
  assign bus.HWUSERM    = data_vld_q ? wuser_a[data_port_q] : '0;
  assign bus.HREADYMUXM = slave_sel_q ? bus.HREADYOUTM : 1'b1;
  // beat_cnt counts SEQ beats still owed by a fixed-length burst
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (bus.HSELM)
      beat_cnt_d = bus.HTRANSM == 2'b10 ? (bus.HBURSTM[2:1] == 2'd3 ? 4'd15 :
                                           bus.HBURSTM[2:1] == 2'd2 ? 4'd7 :
                                           bus.HBURSTM[2:1] == 2'd1 ? 4'd3 : 4'd0) :
                   bus.HTRANSM == 2'b11 ? beat_cnt_q - {3'b000, |beat_cnt_q} :
                   bus.HTRANSM == 2'b00 ? 4'd0 : beat_cnt_q;
  end
  assign hsel_lock_d = (bus.HSELM & bus.HTRANSM[1] & bus.HMASTLOCKM) | (hsel_lock_q & bus.HMASTLOCKM);
  assign hlock_arb   = bus.HMASTLOCKM & (hsel_lock_q | bus.HSELM);
  assign hold        = !no_port_q & (hlock_arb | bus.HTRANSM == 2'b01 | beat_cnt_d != 4'd0);
  always_comb begin
    win = rr_ptr_q;
`ifdef AHB_OSTG_FIXED_PRIO_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      win = req[i] ? PIDX_W'(i) : win;
`else
    for (int k = NUM_PORTS; k >= 1; k--) begin
      logic [PIDX_W:0] idx;
      idx = {1'b0, rr_ptr_q} + (PIDX_W+1)'(k);
      idx = idx >= (PIDX_W+1)'(NUM_PORTS) ? idx - (PIDX_W+1)'(NUM_PORTS) : idx;
      win = req[idx[PIDX_W-1:0]] ? idx[PIDX_W-1:0] : win;
    end
`endif
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      grant_q     <= '0;
      no_port_q   <= 1'b1;
      rr_ptr_q    <= PIDX_W'(NUM_PORTS - 1);
      data_port_q <= '0;
      data_vld_q  <= 1'b0;
      slave_sel_q <= 1'b0;
      hsel_lock_q <= 1'b0;
      beat_cnt_q  <= 4'd0;
    end else if (bus.HREADYMUXM) begin
      slave_sel_q <= bus.HSELM;
      hsel_lock_q <= hsel_lock_d;
      beat_cnt_q  <= beat_cnt_d;
      data_port_q <= grant_q;
      data_vld_q  <= !no_port_q;
      if (!hold) begin
        grant_q   <= any_req ? win : grant_q;
        rr_ptr_q  <= any_req ? win : rr_ptr_q;
        no_port_q <= !any_req;
      end
    end
endmodule

// File: tb/tb_ahb_out_stage_rr.sv
// tb_ahb_out_stage_rr: directed scenarios plus randomized traffic against a transaction-level ownership model
module tb_ahb_out_stage_rr;
  localparam int N = 4;
`ifdef AHB_OSTG_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  ahb_out_stage_rr_if #(.NUM_PORTS(N), .ADDR_W(32), .DATA_W(32), .USER_W(32)) bus ();
  ahb_out_stage_rr #(.NUM_PORTS(N), .ADDR_W(32), .DATA_W(32), .USER_W(32)) dut (
    .HCLK(clk), .HRESET(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    bus.sel_op = '0; bus.held_tran_op = '0; bus.write_op = '0; bus.mastlock_op = '0;
    bus.trans_op = '0; bus.size_op = '0; bus.burst_op = '0; bus.prot_op = '0; bus.master_op = '0;
    bus.addr_op = '0; bus.auser_op = '0; bus.wuser_op = '0; bus.wdata_op = '0;
    bus.HREADYOUTM = 1'b1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic set_port(input int p, input logic [1:0] tr, input logic [2:0] bst, input logic wr, input logic lk);
    bus.sel_op[p] = 1'b1;
    bus.held_tran_op[p] = 1'b1;
    bus.trans_op[2*p +: 2] = tr;
    bus.burst_op[3*p +: 3] = bst;
    bus.size_op[3*p +: 3] = 3'b010;
    bus.write_op[p] = wr;
    bus.mastlock_op[p] = lk;
    bus.addr_op[32*p +: 32] = 32'h2000_0000 + p;
    bus.wdata_op[32*p +: 32] = 32'hA5A5_0000 + p;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    step();
    #1;
    checks++; if (bus.HSELM !== 1'b0) begin failures++; $display("FAIL reset_hsel got=%0b exp=0", bus.HSELM); end
    checks++; if (bus.HTRANSM !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%0d exp=0", bus.HTRANSM); end
    checks++; if (bus.HREADYMUXM !== 1'b1) begin failures++; $display("FAIL reset_hreadymux got=%0b exp=1", bus.HREADYMUXM); end
    checks++; if (bus.active_op !== 4'b0000) begin failures++; $display("FAIL reset_active got=%b exp=0000", bus.active_op); end
    checks++; if (bus.HWDATAM !== 32'h0) begin failures++; $display("FAIL reset_hwdata got=%h exp=0", bus.HWDATAM); end
    checks++; if (bus.HADDRM !== 32'h0) begin failures++; $display("FAIL reset_haddr got=%h exp=0", bus.HADDRM); end
    rst = 1'b0;
    step();
    step();
    checks++; if (bus.HSELM !== 1'b0) begin failures++; $display("FAIL idle_hsel got=%0b exp=0", bus.HSELM); end
    checks++; if (bus.active_op !== 4'b0000) begin failures++; $display("FAIL idle_active got=%b exp=0000", bus.active_op); end
    checks++; if (bus.HREADYMUXM !== 1'b1) begin failures++; $display("FAIL idle_hreadymux got=%0b exp=1", bus.HREADYMUXM); end
  endtask
  task automatic test_round_robin;
    logic [3:0] exp;
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 2'b10, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      exp = FIXED ? 4'b0001 : 4'b0001 << (k % 4);
      checks++; if (bus.active_op !== exp) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, bus.active_op, exp); end
      if (k == 0) begin
        checks++; if (bus.HSELM !== 1'b1) begin failures++; $display("FAIL rr_hsel got=%0b exp=1", bus.HSELM); end
        checks++; if (bus.HTRANSM !== 2'b10) begin failures++; $display("FAIL rr_htrans got=%0d exp=2", bus.HTRANSM); end
      end
    end
  endtask
  task automatic test_burst_hold;
    logic [1:0] tr [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       hr [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp;
    do_reset();
    set_port(1, 2'b10, 3'b011, 1'b0, 1'b0);
    set_port(2, 2'b10, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      bus.trans_op[3:2] = tr[k];
      bus.HREADYOUTM = hr[k];
      #1;
      checks++; if (bus.active_op !== 4'b0010) begin failures++; $display("FAIL burst_owner[%0d] got=%b exp=0010", k, bus.active_op); end
      checks++; if (bus.HREADYMUXM !== hr[k]) begin failures++; $display("FAIL burst_ready[%0d] got=%0b exp=%0b", k, bus.HREADYMUXM, hr[k]); end
    end
    step();
    bus.sel_op[1] = 1'b0; bus.held_tran_op[1] = 1'b0; bus.trans_op[3:2] = 2'b00;
    #1;
    exp = FIXED ? 4'b0010 : 4'b0100;
    checks++; if (bus.active_op !== exp) begin failures++; $display("FAIL burst_next got=%b exp=%b", bus.active_op, exp); end
    checks++; if (bus.HTRANSM !== 2'b10) begin failures++; $display("FAIL burst_next_htrans got=%0d exp=2", bus.HTRANSM); end
  endtask
  task automatic test_lock;
    logic [3:0] exp;
    do_reset();
    set_port(0, 2'b10, 3'b000, 1'b0, 1'b1);
    set_port(3, 2'b10, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      bus.sel_op[0] = (k != 1);
      bus.mastlock_op[0] = (k != 3);
      #1;
      checks++; if (bus.active_op !== 4'b0001) begin failures++; $display("FAIL lock_owner[%0d] got=%b exp=0001", k, bus.active_op); end
    end
    step();
    #1;
    exp = FIXED ? 4'b0001 : 4'b1000;
    checks++; if (bus.active_op !== exp) begin failures++; $display("FAIL lock_release got=%b exp=%b", bus.active_op, exp); end
  endtask
  task automatic test_wdata;
    logic [31:0] exp;
    do_reset();
    set_port(2, 2'b10, 3'b000, 1'b1, 1'b0);
    set_port(3, 2'b10, 3'b000, 1'b1, 1'b0);
    step();
    #1;
    checks++; if (bus.active_op !== 4'b0100) begin failures++; $display("FAIL wr_owner got=%b exp=0100", bus.active_op); end
    checks++; if (bus.HADDRM !== 32'h2000_0002) begin failures++; $display("FAIL wr_haddr got=%h exp=20000002", bus.HADDRM); end
    checks++; if (bus.HWRITEM !== 1'b1) begin failures++; $display("FAIL wr_hwrite got=%0b exp=1", bus.HWRITEM); end
    checks++; if (bus.HWDATAM !== 32'h0) begin failures++; $display("FAIL wr_hwdata0 got=%h exp=0", bus.HWDATAM); end
    step();
    #1;
    checks++; if (bus.HWDATAM !== 32'hA5A5_0002) begin failures++; $display("FAIL wr_hwdata1 got=%h exp=a5a50002", bus.HWDATAM); end
    step();
    #1;
    exp = FIXED ? 32'hA5A5_0002 : 32'hA5A5_0003;
    checks++; if (bus.HWDATAM !== exp) begin failures++; $display("FAIL wr_hwdata2 got=%h exp=%h", bus.HWDATAM, exp); end
  endtask
  task automatic test_reset_mid_burst;
    do_reset();
    set_port(1, 2'b10, 3'b101, 1'b0, 1'b0);
    step();
    #1;
    checks++; if (bus.active_op !== 4'b0010) begin failures++; $display("FAIL mrst_owner got=%b exp=0010", bus.active_op); end
    step();
    bus.trans_op[3:2] = 2'b11;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.HSELM !== 1'b0) begin failures++; $display("FAIL mrst_hsel got=%0b exp=0", bus.HSELM); end
    checks++; if (bus.active_op !== 4'b0000) begin failures++; $display("FAIL mrst_active got=%b exp=0000", bus.active_op); end
    checks++; if (bus.HTRANSM !== 2'b00) begin failures++; $display("FAIL mrst_htrans got=%0d exp=0", bus.HTRANSM); end
    checks++; if (bus.HREADYMUXM !== 1'b1) begin failures++; $display("FAIL mrst_hreadymux got=%0b exp=1", bus.HREADYMUXM); end
    step();
    rst = 1'b0;
    clear_inputs();
    set_port(0, 2'b10, 3'b000, 1'b0, 1'b0);
    set_port(2, 2'b10, 3'b000, 1'b0, 1'b0);
    step();
    #1;
    checks++; if (bus.active_op !== 4'b0001) begin failures++; $display("FAIL mrst_rearb got=%b exp=0001", bus.active_op); end
  endtask
  task automatic test_random;
    int own, last, beats, dport, nb, w, c, o;
    bit lk, ssel, on, psel, plk, prdy, hold;
    logic [1:0] ptr;
    logic [2:0] pbst;
    logic [3:0] pact;
    logic [31:0] paddr, pwd;
    logic [N-1:0] req;
    do_reset();
    own = -1; last = N - 1; beats = 0; dport = -1; lk = 0; ssel = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step();
      bus.sel_op = 4'($urandom); bus.held_tran_op = 4'($urandom | $urandom);
      bus.trans_op = 8'($urandom); bus.write_op = 4'($urandom);
      bus.mastlock_op = 4'($urandom & $urandom & $urandom);
      bus.size_op = 12'($urandom); bus.burst_op = 12'($urandom);
      bus.prot_op = 16'($urandom); bus.master_op = 16'($urandom);
      for (int p = 0; p < N; p++) begin
        bus.addr_op[32*p +: 32] = $urandom; bus.wdata_op[32*p +: 32] = $urandom;
        bus.auser_op[32*p +: 32] = $urandom; bus.wuser_op[32*p +: 32] = $urandom;
      end
      bus.HREADYOUTM = ($urandom % 4) != 0;
      #1;
      on = own >= 0;
      o = on ? own : 0;
      psel = on && bus.sel_op[o];
      plk = on && bus.mastlock_op[o];
      ptr = on ? bus.trans_op[2*o +: 2] : 2'b00;
      pbst = on ? bus.burst_op[3*o +: 3] : 3'b000;
      paddr = on ? bus.addr_op[32*o +: 32] : 32'h0;
      pact = on ? 4'b0001 << o : 4'b0000;
      prdy = ssel ? bus.HREADYOUTM : 1'b1;
      pwd = dport >= 0 ? bus.wdata_op[32*dport +: 32] : 32'h0;
      checks++; if (bus.active_op !== pact) begin failures++; $display("FAIL rnd_active[%0d] got=%b exp=%b", cyc, bus.active_op, pact); end
      checks++; if ({bus.HSELM, bus.HTRANSM, bus.HMASTLOCKM, bus.HBURSTM, bus.HADDRM} !== {psel, ptr, plk, pbst, paddr}) begin
        failures++; $display("FAIL rnd_addr[%0d] got=%b/%0d/%h exp=%b/%0d/%h", cyc, bus.HSELM, bus.HTRANSM, bus.HADDRM, psel, ptr, paddr);
      end
      checks++; if (bus.HREADYMUXM !== prdy) begin failures++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", cyc, bus.HREADYMUXM, prdy); end
      checks++; if (bus.HWDATAM !== pwd) begin failures++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", cyc, bus.HWDATAM, pwd); end
      if (prdy) begin
        nb = beats;
        if (psel && ptr == 2'b10) nb = pbst >= 3'd2 ? (2 << (pbst >> 1)) - 1 : 0;
        else if (psel && ptr == 2'b11 && nb > 0) nb--;
        else if (psel && ptr == 2'b00) nb = 0;
        hold = on && ((plk && (lk || psel)) || ptr == 2'b01 || nb != 0);
        lk = (psel && ptr[1] && plk) || (lk && plk);
        beats = nb; ssel = psel; dport = own;
        req = bus.sel_op & bus.held_tran_op;
        if (!hold) begin
          w = -1;
          for (int k = 1; k <= N; k++) begin
            c = FIXED ? k - 1 : (last + k) % N;
            if (req[c] && w < 0) w = c;
          end
          if (w >= 0) begin own = w; last = w; end else own = -1;
        end
      end
    end
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_burst_hold();
    test_lock();
    test_wdata();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
